// File: rtl/icebreaker_uart_alu.sv
// icebreaker_uart_alu: UART packet engine with echo, add32 and mul32 commands over 8N1 serial
module icebreaker_uart_alu #(
    parameter int CLK_FREQ_HZ = 31500000,
    parameter int BAUD_RATE   = 76800,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic tx_o
);
    localparam int BIT_CYC = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYC + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD = 8'hAD;
    localparam logic [7:0] OP_MUL = 8'h8A;

    typedef enum logic [2:0] {OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, EXEC, RESP} state_t;

    logic          rx_meta, rx_sync, rx_prev, rx_busy, rx_valid;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;
    logic          tx_busy;
    logic [3:0]    tx_bits;
    logic [CW-1:0] tx_cnt;
    logic [8:0]    tx_sh;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_empty, fifo_full, fifo_push, tx_pop;
    logic          push_req;
    logic [7:0]    push_data;
    state_t        state_q, state_d;
    logic [7:0]    opcode_q, len_lo_q, echo_data_q;
    logic [15:0]   remain_q, len_full;
    logic [31:0]   opnd_q, acc_q, op_word;
    logic [1:0]    byte_idx_q, resp_idx_q;
    logic          have_q, echo_push_q, is_alu;

    assign fifo_empty = fifo_cnt == '0;
    assign fifo_full  = fifo_cnt == (AW+1)'(FIFO_DEPTH);
    assign fifo_push  = push_req && !fifo_full;
    assign tx_pop     = !tx_busy && !fifo_empty;
    assign len_full   = {rx_sh, len_lo_q};
    assign op_word    = {rx_sh, opnd_q[31:8]};
    assign is_alu     = opcode_q == OP_ADD || opcode_q == OP_MUL;

    // Receiver: synchronise, detect start on falling edge, sample every bit at its centre
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_valid <= 1'b0;
            rx_bit   <= '0;
            rx_cnt   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_meta  <= rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt  <= '0;
                    rx_bit  <= 4'd1;
                    rx_busy <= !rx_sync;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd9) begin
                    rx_busy  <= 1'b0;
                    rx_valid <= rx_sync;
                end else begin
                    rx_sh <= {rx_sync, rx_sh[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Transmitter: load start bit on accept, then shift 8 data bits and a full stop bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_o    <= 1'b1;
            tx_busy <= 1'b0;
            tx_bits <= '0;
            tx_cnt  <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (!fifo_empty) begin
                tx_busy <= 1'b1;
                tx_o    <= 1'b0;
                tx_sh   <= {1'b1, fifo_mem[rd_ptr]};
                tx_bits <= 4'd9;
                tx_cnt  <= '0;
            end
        end else if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            if (tx_bits == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                tx_o    <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_bits <= tx_bits - 4'd1;
            end
        end
    end

    // TX FIFO pointers and occupancy; a push into a full FIFO is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            wr_ptr   <= fifo_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= tx_pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_cnt <= fifo_cnt + (AW+1)'(fifo_push) - (AW+1)'(tx_pop);
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_i) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= push_data;
    end

    // Parser state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= OPCODE;
        else
            state_q <= state_d;
    end

    // Parser next state and FIFO push source; bytes arriving in EXEC/RESP are ignored
    always_comb begin
        state_d   = state_q;
        push_req  = echo_push_q;
        push_data = echo_data_q;
        case (state_q)
            OPCODE:  state_d = rx_valid ? RSVD : OPCODE;
            RSVD:    state_d = rx_valid ? LEN_LO : RSVD;
            LEN_LO:  state_d = rx_valid ? LEN_HI : LEN_LO;
            LEN_HI:  state_d = !rx_valid ? LEN_HI : len_full > 16'd4 ? PAYLOAD : OPCODE;
            PAYLOAD: state_d = !(rx_valid && remain_q == 16'd1) ? PAYLOAD : is_alu ? EXEC : OPCODE;
            EXEC:    state_d = have_q ? RESP : OPCODE;
            RESP: begin
                push_req  = 1'b1;
                push_data = acc_q[7:0];
                state_d   = (!fifo_full && resp_idx_q == 2'd3) ? OPCODE : RESP;
            end
            default: state_d = OPCODE;
        endcase
    end

    // Parser datapath: header capture, operand assembly, accumulate, result unload
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q    <= '0;
            len_lo_q    <= '0;
            remain_q    <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            byte_idx_q  <= '0;
            resp_idx_q  <= '0;
            have_q      <= 1'b0;
            echo_push_q <= 1'b0;
            echo_data_q <= '0;
        end else begin
            echo_push_q <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    OPCODE: begin
                        opcode_q   <= rx_sh;
                        byte_idx_q <= '0;
                        resp_idx_q <= '0;
                        have_q     <= 1'b0;
                        acc_q      <= '0;
                    end
                    LEN_LO: len_lo_q <= rx_sh;
                    LEN_HI: remain_q <= len_full - 16'd4;
                    PAYLOAD: begin
                        remain_q    <= remain_q - 16'd1;
                        echo_push_q <= opcode_q == OP_ECHO;
                        echo_data_q <= rx_sh;
                        opnd_q      <= op_word;
                        byte_idx_q  <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            have_q <= 1'b1;
                            acc_q  <= !have_q ? op_word : opcode_q == OP_ADD ? acc_q + op_word : acc_q * op_word;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == RESP && !fifo_full) begin
                acc_q      <= acc_q >> 8;
                resp_idx_q <= resp_idx_q + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_icebreaker_uart_alu.sv
// tb_icebreaker_uart_alu: directed packet vectors with a serial decoder on tx_o
module tb_icebreaker_uart_alu;
    localparam int BIT = 16;

    typedef struct {
        logic [127:0] pkt;
        int           n_in;
        logic [31:0]  rsp;
        int           n_rsp;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       rx_i = 1'b1;
    logic       tx_o;
    logic [7:0] got [$];
    logic [7:0] mon_b;
    vec_t       vecs [11];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         bad_stop = 0;

    icebreaker_uart_alu #(
        .CLK_FREQ_HZ(1600000),
        .BAUD_RATE(100000),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .rx_i(rx_i),
        .tx_o(tx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (BIT) @(negedge clk_i);
        for (int j = 0; j < 8; j++) begin
            rx_i = b[j];
            repeat (BIT) @(negedge clk_i);
        end
        rx_i = stop;
        repeat (BIT) @(negedge clk_i);
        rx_i = 1'b1;
    endtask

    task automatic send_pkt(input logic [127:0] p, input int n);
        for (int k = 0; k < n; k++)
            send_byte(p[127-8*k -: 8], 1'b1);
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] r, input int n);
        repeat (50 * BIT) @(negedge clk_i);
        chk($sformatf("%s count", name), got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++)
            chk($sformatf("%s byte%0d", name, k), got[k], r[31-8*k -: 8]);
        chk($sformatf("%s idle", name), tx_o, 1'b1);
    endtask

    initial begin
        wait (rst_ni);
        forever begin
            @(negedge tx_o);
            repeat (BIT / 2) @(negedge clk_i);
            for (int j = 0; j < 8; j++) begin
                repeat (BIT) @(negedge clk_i);
                mon_b[j] = tx_o;
            end
            repeat (BIT) @(negedge clk_i);
            if (!tx_o)
                bad_stop++;
            got.push_back(mon_b);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got %0d expected finish", n_cmp);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{128'hEC000800_EFBEADDE_00000000_00000000, 8,  32'hEFBEADDE, 4};
        vecs[1]  = '{128'hAD000C00_01000000_FFFFFFFF_00000000, 12, 32'h00000000, 4};
        vecs[2]  = '{128'h8A000C00_03000000_05000000_00000000, 12, 32'h0F000000, 4};
        vecs[3]  = '{128'h55000800_11223344_00000000_00000000, 8,  32'h00000000, 0};
        vecs[4]  = '{128'hEC7F0500_A5000000_00000000_00000000, 5,  32'hA5000000, 1};
        vecs[5]  = '{128'hAD000B00_10000000_22334400_00000000, 11, 32'h10000000, 4};
        vecs[6]  = '{128'hAD000700_01020300_00000000_00000000, 7,  32'h00000000, 0};
        vecs[7]  = '{128'hEC000200_00000000_00000000_00000000, 4,  32'h00000000, 0};
        vecs[8]  = '{128'h8A000800_78563412_00000000_00000000, 8,  32'h78563412, 4};
        vecs[9]  = '{128'hAD001000_FFFFFF7F_01000000_02000000, 16, 32'h02000080, 4};
        vecs[10] = '{128'h8A000C00_00000100_00000100_00000000, 12, 32'h00000000, 4};

        repeat (5) @(negedge clk_i);
        chk("reset tx_o low-phase", tx_o, 1'b1);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("post-reset tx_o", tx_o, 1'b1);
        chk("post-reset quiet", got.size(), 0);

        for (int i = 0; i < 11; i++) begin
            got.delete();
            send_pkt(vecs[i].pkt, vecs[i].n_in);
            expect_rsp($sformatf("vec%0d", i), vecs[i].rsp, vecs[i].n_rsp);
        end

        got.delete();
        send_byte(8'hEC, 1'b0);
        repeat (2 * BIT) @(negedge clk_i);
        send_pkt(128'hEC000500_5A000000_00000000_00000000, 5);
        expect_rsp("framing", 32'h5A000000, 1);

        got.delete();
        send_pkt(128'hEC000800_00000000_00000000_00000000, 6);
        rx_i = 1'b0;
        repeat (BIT + BIT / 2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 chk("async reset tx_o", tx_o, 1'b1);
        rx_i = 1'b1;
        repeat (4 * BIT) @(negedge clk_i);
        chk("held reset tx_o", tx_o, 1'b1);
        repeat (8 * BIT) @(negedge clk_i);
        chk("late reset tx_o", tx_o, 1'b1);
        rst_ni = 1'b1;
        got.delete();
        repeat (2 * BIT) @(negedge clk_i);
        send_pkt(128'hEC000600_12340000_00000000_00000000, 6);
        expect_rsp("after reset", 32'h12340000, 2);

        chk("stop bits", bad_stop, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
